signed_int_divider: RTL and testbench

Parametrised sequential integer divider, the next generation of the team's radix-2 divider. Computes one WIDTH-bit quotient/remainder pair per request, in signed or unsigned mode chosen per operation. Uses valid/ready handshakes on both input and output, and flags divide-by-zero and signed overflow without running the iteration loop. It sits between an issue stage and a result-writeback stage, and both may stall it.

---
 rtl/int_div_pkg.sv | 24 ++
 rtl/int_div_step.sv | 23 ++
 rtl/signed_int_divider.sv | 161 ++++++++++++++++
 tb/tb_signed_int_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_pkg.sv
// Shared types and helpers for the signed integer divider.
// Sign helpers work at 64 bits; callers truncate to WIDTH.
package int_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic logic [63:0] neg64(
    input logic [63:0] x
  );
    return ~x + 64'd1;
  endfunction

  function automatic logic [63:0] cneg64(
    input logic [63:0] x,
    input logic        n
  );
    return n ? neg64(x) : x;
  endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor when it fits.
module int_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_prem,
  input  logic [WIDTH-1:0] i_dvs,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_dvs_ext;

  assign w_shift   = {i_prem, i_bit};
  assign w_dvs_ext = {2'b00, i_dvs};
  assign o_qbit    = (w_shift >= w_dvs_ext);
  assign o_rem     = o_qbit
                   ? (WIDTH+1)'(w_shift - w_dvs_ext)
                   : (WIDTH+1)'(w_shift);

endmodule

// File: rtl/signed_int_divider.sv
// Radix-2 restoring divider, signed/unsigned per request,
// valid/ready on both sides, early-out for div-by-zero/overflow.
module signed_int_divider
  import int_div_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DataVal,
  output logic             DataRdy,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             ResultVal,
  input  logic             ResultRdy,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZeroExc,
  output logic             OverflowExc
);

  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LOGWIDTH-1:0] LAST =
    LOGWIDTH'(WIDTH-1);

  div_state_t          r_state;
  logic [WIDTH-1:0]    r_dvd;
  logic [WIDTH-1:0]    r_dvs;
  logic [WIDTH:0]      r_rem;
  logic [WIDTH-1:0]    r_quo;
  logic [LOGWIDTH-1:0] r_cnt;
  logic                r_qsign;
  logic                r_rsign;
  logic                r_rv;
  logic [WIDTH-1:0]    r_q_out;
  logic [WIDTH-1:0]    r_r_out;
  logic                r_dbz;
  logic                r_ovf;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_dbz;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_nx;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_dvd_neg = Signed & Dividend[WIDTH-1];
  assign w_dvs_neg = Signed & Divisor[WIDTH-1];
  assign w_dvd_mag =
    WIDTH'(cneg64(64'(Dividend), w_dvd_neg));
  assign w_dvs_mag =
    WIDTH'(cneg64(64'(Divisor), w_dvs_neg));

  assign w_dbz = (Divisor == '0);
  assign w_ovf = Signed & (Dividend == MIN)
               & (Divisor == '1);

  int_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_prem (r_rem),
    .i_dvs  (r_dvs),
    .i_bit  (r_dvd[WIDTH-1]),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  assign w_quo_nx = WIDTH'({r_quo, w_qbit});
  assign w_q_fin  =
    WIDTH'(cneg64(64'(w_quo_nx), r_qsign));
  assign w_r_fin  =
    WIDTH'(cneg64(64'(WIDTH'(w_rem_nx)), r_rsign));

  // Ready is forced low while reset is asserted.
  assign DataRdy      = RST & (r_state == IDLE);
  assign ResultVal    = r_rv;
  assign Quotient     = r_q_out;
  assign Remainder    = r_r_out;
  assign DivByZeroExc = r_dbz;
  assign OverflowExc  = r_ovf;

  // Control FSM plus iteration datapath and result registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_rv    <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (DataVal) begin
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_qsign <= w_dvd_neg ^ w_dvs_neg;
            r_rsign <= w_dvd_neg;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= LAST;
            if (w_dbz) begin
              r_q_out <= '1;
              r_r_out <= Dividend;
              r_dbz   <= 1'b1;
              r_ovf   <= 1'b0;
              r_rv    <= 1'b1;
              r_state <= DONE;
            end else if (w_ovf) begin
              r_q_out <= MIN;
              r_r_out <= '0;
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b1;
              r_rv    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= r_dvd << 1;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_q_out <= w_q_fin;
            r_r_out <= w_r_fin;
            r_rv    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (ResultRdy) begin
            r_rv    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_int_divider.sv
// Directed-vector bench for signed_int_divider at WIDTH=8.
// Expected values are hand-computed constants.
module tb_signed_int_divider;

  logic       CLK;
  logic       RST;
  logic       DataVal;
  logic       DataRdy;
  logic       Signed;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic       ResultVal;
  logic       ResultRdy;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       DivByZeroExc;
  logic       OverflowExc;

  int n_checks;
  int n_errors;

  signed_int_divider #(
    .WIDTH (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .DataVal      (DataVal),
    .DataRdy      (DataRdy),
    .Signed       (Signed),
    .Dividend     (Dividend),
    .Divisor      (Divisor),
    .ResultVal    (ResultVal),
    .ResultRdy    (ResultRdy),
    .Quotient     (Quotient),
    .Remainder    (Remainder),
    .DivByZeroExc (DivByZeroExc),
    .OverflowExc  (OverflowExc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!DataRdy && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!DataRdy) chk({tag, "_rdy_to"}, 0, 1);
  endtask

  // Returns edges after accept until ResultVal rises.
  task automatic wait_res(
    input  string tag,
    output int    lat
  );
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!ResultVal && lat < 40);
    if (!ResultVal) chk({tag, "_res_to"}, 0, 1);
  endtask

  task automatic issue(
    input logic       sg,
    input logic [7:0] a,
    input logic [7:0] b
  );
    @(negedge CLK);
    Signed   = sg;
    Dividend = a;
    Divisor  = b;
    DataVal  = 1'b1;
    @(posedge CLK);
    #1;
    DataVal  = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(negedge CLK);
    ResultRdy = 1'b1;
    @(posedge CLK);
    #1;
    ResultRdy = 1'b0;
    chk({tag, "_rv_low"}, 32'(ResultVal), 0);
    chk({tag, "_rdy_hi"}, 32'(DataRdy), 1);
  endtask

  task automatic do_op(
    input string      tag,
    input logic       sg,
    input logic [7:0] a,
    input logic [7:0] b,
    input int         elat,
    input logic [7:0] eq,
    input logic [7:0] er,
    input logic       edbz,
    input logic       eovf
  );
    int lat;
    wait_rdy(tag);
    issue(sg, a, b);
    wait_res(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, 32'(Quotient), 32'(eq));
    chk({tag, "_r"}, 32'(Remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(DivByZeroExc), 32'(edbz));
    chk({tag, "_ovf"}, 32'(OverflowExc), 32'(eovf));
    drain(tag);
  endtask

  initial begin
    int lat;
    logic [19:0] snap;
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b0;
    DataVal   = 1'b0;
    ResultRdy = 1'b0;
    Signed    = 1'b0;
    Dividend  = '0;
    Divisor   = '0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdy", 32'(DataRdy), 0);
    chk("rst_rv", 32'(ResultVal), 0);
    chk("rst_q", 32'(Quotient), 0);
    chk("rst_r", 32'(Remainder), 0);
    chk("rst_exc",
        32'({DivByZeroExc, OverflowExc}), 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rel_rdy", 32'(DataRdy), 1);

    do_op("u200_3", 0, 8'd200, 8'd3,
          8, 8'd66, 8'd2, 0, 0);
    do_op("sm7_2", 1, 8'hF9, 8'h02,
          8, 8'hFD, 8'hFF, 0, 0);
    do_op("s7_m2", 1, 8'h07, 8'hFE,
          8, 8'hFD, 8'h01, 0, 0);
    do_op("u37_0", 0, 8'd37, 8'd0,
          1, 8'hFF, 8'd37, 1, 0);
    do_op("sovf", 1, 8'h80, 8'hFF,
          1, 8'h80, 8'h00, 0, 1);
    do_op("u80_ff", 0, 8'h80, 8'hFF,
          8, 8'h00, 8'h80, 0, 0);
    do_op("sm100_7", 1, 8'h9C, 8'h07,
          8, 8'hF2, 8'hFE, 0, 0);
    do_op("u255_1", 0, 8'hFF, 8'h01,
          8, 8'hFF, 8'h00, 0, 0);
    do_op("sm5_0", 1, 8'hFB, 8'h00,
          1, 8'hFF, 8'hFB, 1, 0);
    do_op("sm128_2", 1, 8'h80, 8'h02,
          8, 8'hC0, 8'h00, 0, 0);
    do_op("sm128_m128", 1, 8'h80, 8'h80,
          8, 8'h01, 8'h00, 0, 0);

    // Backpressure: 50/5 held for 20 cycles.
    wait_rdy("bp");
    issue(0, 8'd50, 8'd5);
    wait_res("bp", lat);
    snap = {Quotient, Remainder,
            DivByZeroExc, OverflowExc, 2'b00};
    chk("bp_q", 32'(Quotient), 32'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      chk("bp_hold",
          32'({Quotient, Remainder, DivByZeroExc,
               OverflowExc, ResultVal, DataRdy}),
          32'({snap[19:2], 1'b1, 1'b0}));
    end

    // Drain and a simultaneous request: only drain acts.
    @(negedge CLK);
    ResultRdy = 1'b1;
    DataVal   = 1'b1;
    Signed    = 1'b0;
    Dividend  = 8'd100;
    Divisor   = 8'd9;
    @(posedge CLK);
    #1;
    ResultRdy = 1'b0;
    chk("b2b_rv_low", 32'(ResultVal), 0);
    chk("b2b_rdy", 32'(DataRdy), 1);
    @(posedge CLK);
    #1;
    DataVal = 1'b0;
    chk("b2b_acc", 32'(DataRdy), 0);
    wait_res("b2b", lat);
    chk("b2b_lat", 32'(lat), 8);
    chk("b2b_q", 32'(Quotient), 32'd11);
    chk("b2b_r", 32'(Remainder), 32'd1);
    drain("b2b");

    // Reset during CALC abandons the operation.
    wait_rdy("rc");
    issue(0, 8'd200, 8'd3);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rc_rdy_low", 32'(DataRdy), 0);
    @(posedge CLK);
    #1;
    chk("rc_rv", 32'(ResultVal), 0);
    chk("rc_q", 32'(Quotient), 0);
    chk("rc_r", 32'(Remainder), 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) begin
      @(posedge CLK);
      #1;
      chk("rc_no_rv", 32'(ResultVal), 0);
    end
    do_op("u100_7", 0, 8'd100, 8'd7,
          8, 8'd14, 8'd2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
